// File: rtl/alu_seq.sv
// alu_seq: sequences CPU-side requests onto an external multi-cycle ALU,
// mirrors its compare flags and mode bits, and guards each op with a timeout.
module alu_seq #(
  parameter int unsigned TIMEOUT = 31
) (
  input  logic        clk,
  input  logic        rst,
  // CPU side
  input  logic        op_valid,
  output logic        op_ready,
  input  logic [9:0]  op_ir,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  // results and status
  output logic        res_valid,
  output logic [15:0] res_data,
  output logic [3:0]  flags,
  output logic [2:0]  modes,
  output logic        err_timeout,
  // ALU side
  output logic        alu_start,
  output logic [9:0]  alu_ir,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic        alu_oe,
  output logic        alu_carryin,
  input  logic        alu_done,
  input  logic [15:0] alu_out,
  input  logic        alu_carryout,
  input  logic        alu_overout,
  input  logic        alu_cmpo
);

  localparam int unsigned IR_W  = 10;
  localparam int unsigned CNT_W = 5;

  localparam logic [IR_W-1:0]  IR_FLAGS_CLR = IR_W'(10'h0B9);
  localparam logic [IR_W-1:0]  IR_MODE_LO   = IR_W'(10'h0BA);
  localparam logic [IR_W-1:0]  IR_MODE_HI   = IR_W'(10'h0BF);
  localparam logic [CNT_W-1:0] CNT_LAST     = CNT_W'(TIMEOUT - 1);

  // bit positions inside flags {Z,C,V,N} and modes {signed_en,carry_en,flags_en}
  localparam int unsigned FLAG_Z      = 3;
  localparam int unsigned FLAG_C      = 2;
  localparam int unsigned FLAG_V      = 1;
  localparam int unsigned FLAG_N      = 0;
  localparam int unsigned MODE_SIGNED = 2;
  localparam int unsigned MODE_CARRY  = 1;
  localparam int unsigned MODE_FLAGS  = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_LOW,
    S_WAIT_HIGH,
    S_CAPTURE,
    S_MODE,
    S_MODE_WAIT
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cyc_cnt;
  logic               cmp_seen;
  logic               pend_c;
  logic               pend_v;

  logic               is_mode_op_c;
  logic               timeout_hit_c;

  // mode ops occupy a small opcode window and bypass the ALU handshake
  assign is_mode_op_c  = (op_ir >= IR_MODE_LO) && (op_ir <= IR_MODE_HI);
  assign timeout_hit_c = (cyc_cnt == CNT_LAST);

  // carry-in is a pure function of two registered bits, so it stays glitch-free
  assign alu_carryin = flags[FLAG_C] & modes[MODE_CARRY];

  // sequencer: state, ALU handshake, result/flag/mode registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      op_ready    <= 1'b1;
      res_valid   <= 1'b0;
      res_data    <= '0;
      flags       <= '0;
      modes       <= 3'b001;
      err_timeout <= 1'b0;
      alu_start   <= 1'b0;
      alu_ir      <= '0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_oe      <= 1'b0;
      cyc_cnt     <= '0;
      cmp_seen    <= 1'b0;
      pend_c      <= 1'b0;
      pend_v      <= 1'b0;
    end else begin
      res_valid <= 1'b0;

      // compare results may arrive in any waiting cycle; keep the latest
      if ((state == S_WAIT_LOW || state == S_WAIT_HIGH) && alu_cmpo) begin
        pend_c   <= alu_carryout;
        pend_v   <= alu_overout;
        cmp_seen <= 1'b1;
      end

      case (state)
        S_IDLE: begin
          if (op_valid) begin
            op_ready    <= 1'b0;
            err_timeout <= 1'b0;
            alu_ir      <= op_ir;
            alu_a       <= op_a;
            alu_b       <= op_b;
            if (is_mode_op_c) begin
              state <= S_MODE;
            end else begin
              state     <= S_ISSUE;
              alu_start <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          alu_start <= 1'b0;
          cmp_seen  <= 1'b0;
          cyc_cnt   <= '0;
          state     <= S_WAIT_LOW;
        end

        S_WAIT_LOW: begin
          cyc_cnt <= cyc_cnt + CNT_W'(1);
          if (timeout_hit_c) begin
            err_timeout <= 1'b1;
            alu_ir      <= '0;
            op_ready    <= 1'b1;
            state       <= S_IDLE;
          end else if (!alu_done) begin
            state <= S_WAIT_HIGH;
          end
        end

        S_WAIT_HIGH: begin
          cyc_cnt <= cyc_cnt + CNT_W'(1);
          if (alu_done) begin
            alu_oe <= 1'b1;
            state  <= S_CAPTURE;
          end else if (timeout_hit_c) begin
            err_timeout <= 1'b1;
            alu_ir      <= '0;
            op_ready    <= 1'b1;
            state       <= S_IDLE;
          end
        end

        S_CAPTURE: begin
          res_data  <= alu_out;
          res_valid <= 1'b1;
          alu_oe    <= 1'b0;
          alu_ir    <= '0;
          op_ready  <= 1'b1;
          state     <= S_IDLE;
          if (cmp_seen && modes[MODE_FLAGS]) begin
            if (alu_ir == IR_FLAGS_CLR) begin
              flags <= '0;
            end else begin
              flags[FLAG_Z] <= (alu_out == '0);
              flags[FLAG_C] <= pend_c;
              flags[FLAG_V] <= pend_v;
              flags[FLAG_N] <= alu_out[15];
            end
          end
        end

        S_MODE: begin
          // opcode bits [2:1] select the mode bit, bit 0 is the new value
          case (alu_ir[2:1])
            2'b01:   modes[MODE_FLAGS]  <= alu_ir[0];
            2'b10:   modes[MODE_CARRY]  <= alu_ir[0];
            2'b11:   modes[MODE_SIGNED] <= alu_ir[0];
            default: ;
          endcase
          alu_ir <= '0;
          state  <= S_MODE_WAIT;
        end

        S_MODE_WAIT: begin
          res_valid <= 1'b1;
          op_ready  <= 1'b1;
          state     <= S_IDLE;
        end

        default: begin
          alu_start <= 1'b0;
          alu_oe    <= 1'b0;
          alu_ir    <= '0;
          op_ready  <= 1'b1;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: drives alu_seq against a behavioural team-ALU and checks it
// with a reference model of results, flags and mode bits.
module tb_alu_seq;

  localparam logic [9:0] IR_ADD  = 10'h001;
  localparam logic [9:0] IR_SUB  = 10'h002;
  localparam logic [9:0] IR_XOR  = 10'h003;
  localparam logic [9:0] IR_FCLR = 10'h0B9;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_valid;
  logic        op_ready;
  logic [9:0]  op_ir;
  logic [15:0] op_a;
  logic [15:0] op_b;
  logic        res_valid;
  logic [15:0] res_data;
  logic [3:0]  flags;
  logic [2:0]  modes;
  logic        err_timeout;
  logic        alu_start;
  logic [9:0]  alu_ir;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_oe;
  logic        alu_carryin;
  logic        alu_done;
  logic [15:0] alu_out;
  logic        alu_carryout;
  logic        alu_overout;
  logic        alu_cmpo;

  int n_checks = 0;
  int n_fail   = 0;

  alu_seq #(.TIMEOUT(31)) dut (
    .clk(clk), .rst(rst),
    .op_valid(op_valid), .op_ready(op_ready), .op_ir(op_ir), .op_a(op_a), .op_b(op_b),
    .res_valid(res_valid), .res_data(res_data), .flags(flags), .modes(modes),
    .err_timeout(err_timeout),
    .alu_start(alu_start), .alu_ir(alu_ir), .alu_a(alu_a), .alu_b(alu_b),
    .alu_oe(alu_oe), .alu_carryin(alu_carryin),
    .alu_done(alu_done), .alu_out(alu_out), .alu_carryout(alu_carryout),
    .alu_overout(alu_overout), .alu_cmpo(alu_cmpo)
  );

  always #5 clk = ~clk;

  // arithmetic the team ALU performs; returns {carry, overflow, result}
  function automatic logic [17:0] alu_fn(input logic [9:0] ir, input logic [15:0] a,
                                         input logic [15:0] b, input logic cin);
    logic [16:0] s;
    logic [15:0] r;
    logic        c;
    logic        v;
    case (ir)
      IR_ADD: begin
        s = {1'b0, a} + {1'b0, b} + {16'h0000, cin};
        r = s[15:0]; c = s[16];
        v = (a[15] == b[15]) && (r[15] != a[15]);
      end
      IR_SUB: begin
        s = {1'b0, a} - {1'b0, b};
        r = s[15:0]; c = s[16];
        v = (a[15] != b[15]) && (r[15] != a[15]);
      end
      default: begin
        r = a ^ b; c = 1'b0; v = 1'b0;
      end
    endcase
    return {c, v, r};
  endfunction

  // behavioural team ALU: done drops the cycle after start, rises 6 cycles later
  logic        cmp_en    = 1'b1;
  logic        alu_stuck = 1'b0;
  logic        a_busy;
  logic        a_done;
  logic [3:0]  a_rem;
  logic [15:0] a_res;
  logic        a_c;
  logic        a_v;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      a_busy <= 1'b0; a_done <= 1'b1; a_rem <= 4'd0;
      a_res <= 16'h0000; a_c <= 1'b0; a_v <= 1'b0;
    end else if (a_busy) begin
      if (a_rem == 4'd1) begin
        a_done <= 1'b1;
        a_busy <= 1'b0;
      end
      a_rem <= a_rem - 4'd1;
    end else if (alu_start && !alu_stuck) begin
      {a_c, a_v, a_res} <= alu_fn(alu_ir, alu_a, alu_b, alu_carryin);
      a_done <= 1'b0;
      a_busy <= 1'b1;
      a_rem  <= 4'd6;
    end
  end

  assign alu_done     = a_done;
  assign alu_out      = alu_oe ? a_res : 16'hDEAD;
  assign alu_carryout = a_busy & a_c;
  assign alu_overout  = a_busy & a_v;
  assign alu_cmpo     = a_busy & cmp_en;

  // event counters sampled on the active edge
  int start_cnt = 0;
  int acc_cnt   = 0;
  int rv_cnt    = 0;
  always @(posedge clk) begin
    if (alu_start)            start_cnt <= start_cnt + 1;
    if (op_valid && op_ready) acc_cnt   <= acc_cnt + 1;
    if (res_valid)            rv_cnt    <= rv_cnt + 1;
  end

  // reference model state
  logic [15:0] m_res;
  logic [3:0]  m_flags;
  logic [2:0]  m_modes;
  logic        cin_and;
  logic        cin_or;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // predicted effect of one op on the model (result, flags, modes)
  task automatic predict(input logic [9:0] ir, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] e_res, output logic [3:0] e_flags,
                         output logic [2:0] e_modes);
    logic [17:0] r;
    int k;
    e_res = m_res; e_flags = m_flags; e_modes = m_modes;
    if (ir >= 10'h0BA && ir <= 10'h0BF) begin
      k = int'(ir) - 'h0BA;
      e_modes[k / 2] = (k % 2) == 1;
    end else begin
      r = alu_fn(ir, a, b, m_flags[2] & m_modes[1]);
      e_res = r[15:0];
      if (cmp_en && m_modes[0])
        e_flags = (ir == IR_FCLR) ? 4'h0 : {r[15:0] == 16'h0000, r[17], r[16], r[15]};
    end
  endtask

  // issue one op from IDLE and check its whole life against the model
  task automatic run_op(input logic [9:0] ir, input logic [15:0] a, input logic [15:0] b);
    logic        mode;
    int          lat;
    int          st0;
    logic [15:0] e_res;
    logic [3:0]  e_flags;
    logic [2:0]  e_modes;
    mode = (ir >= 10'h0BA && ir <= 10'h0BF);
    predict(ir, a, b, e_res, e_flags, e_modes);
    check("ready_before_op", 32'(op_ready), 32'(1));
    st0 = start_cnt;
    op_valid = 1'b1; op_ir = ir; op_a = a; op_b = b;
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    check("first_cycle_start", 32'(alu_start), mode ? 32'(0) : 32'(1));
    check("first_cycle_ir", 32'(alu_ir), 32'(ir));
    check("first_cycle_ready", 32'(op_ready), 32'(0));
    check("err_cleared", 32'(err_timeout), 32'(0));
    if (!mode) begin
      check("issue_a", 32'(alu_a), 32'(a));
      check("issue_b", 32'(alu_b), 32'(b));
    end
    cin_and = 1'b1; cin_or = 1'b0;
    while (!res_valid && lat < 40) begin
      cin_and &= alu_carryin;
      cin_or  |= alu_carryin;
      if (mode && lat == 2) check("mode_wait_ir", 32'(alu_ir), 32'(0));
      if (!mode && lat == 9) check("capture_oe", 32'(alu_oe), 32'(1));
      @(negedge clk);
      lat++;
    end
    check("res_latency", 32'(lat), mode ? 32'(3) : 32'(10));
    check("res_data", 32'(res_data), 32'(e_res));
    check("flags", 32'(flags), 32'(e_flags));
    check("modes", 32'(modes), 32'(e_modes));
    check("done_ready", 32'(op_ready), 32'(1));
    check("done_alu_ir", 32'(alu_ir), 32'(0));
    check("done_alu_oe", 32'(alu_oe), 32'(0));
    check("start_pulses", 32'(start_cnt - st0), mode ? 32'(0) : 32'(1));
    @(negedge clk);
    check("res_valid_one_cycle", 32'(res_valid), 32'(0));
    m_res = e_res; m_flags = e_flags; m_modes = e_modes;
  endtask

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat;
    int rv0;
    int st0;
    int acc0;
    logic [15:0] ha;
    logic [15:0] hb;
    logic [3:0]  saved;
    logic [9:0]  rir;
    logic [15:0] e_res;
    logic [3:0]  e_flags;
    logic [2:0]  e_modes;

    rst = 1'b1; op_valid = 1'b0; op_ir = 10'h000; op_a = 16'h0000; op_b = 16'h0000;
    m_res = 16'h0000; m_flags = 4'h0; m_modes = 3'b001;
    repeat (2) @(negedge clk);

    // reset values
    check("rst_res_valid", 32'(res_valid), 32'(0));
    check("rst_res_data", 32'(res_data), 32'(0));
    check("rst_flags", 32'(flags), 32'(0));
    check("rst_modes", 32'(modes), 32'(3'b001));
    check("rst_err", 32'(err_timeout), 32'(0));
    check("rst_alu_start", 32'(alu_start), 32'(0));
    check("rst_alu_ir", 32'(alu_ir), 32'(0));
    check("rst_alu_oe", 32'(alu_oe), 32'(0));
    check("rst_carryin", 32'(alu_carryin), 32'(0));
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready", 32'(op_ready), 32'(1));

    // ADD 1 + FFFF: wraps to zero with carry out
    run_op(IR_ADD, 16'h0001, 16'hFFFF);
    check("add_wrap_data", 32'(res_data), 32'(16'h0000));
    check("add_wrap_flags", 32'(flags), 32'(4'b1100));

    // enable carry, then ADD consumes carry-in for the whole op
    run_op(10'h0BD, 16'h0000, 16'h0000);
    check("carry_en_set", 32'(modes[1]), 32'(1));
    run_op(IR_ADD, 16'h1234, 16'h0101);
    check("carryin_held", 32'({cin_and, cin_or}), 32'(2'b11));

    // flags_en off: compare results must not touch flags
    run_op(10'h0BA, 16'h0000, 16'h0000);
    saved = flags;
    run_op(IR_ADD, 16'h7FFF, 16'h0001);
    check("flags_frozen", 32'(flags), 32'(saved));
    run_op(10'h0BB, 16'h0000, 16'h0000);
    run_op(IR_SUB, 16'h0001, 16'h0002);
    run_op(IR_FCLR, 16'h5555, 16'h1111);
    check("flags_cleared", 32'(flags), 32'(0));

    // randomized mix of ALU and mode ops
    for (int i = 0; i < 24; i++) begin
      case ($urandom_range(0, 4))
        0: rir = IR_ADD;
        1: rir = IR_SUB;
        2: rir = IR_XOR;
        3: rir = IR_FCLR;
        default: rir = 10'(10'h0BA + 10'($urandom_range(0, 5)));
      endcase
      cmp_en = ($urandom_range(0, 3) != 0);
      run_op(rir, 16'($urandom), 16'($urandom));
    end
    cmp_en = 1'b1;
    run_op(IR_SUB, 16'h0003, 16'h0001);

    // ALU never drops done: timeout after 31 waiting cycles, no result
    alu_stuck = 1'b1;
    rv0 = rv_cnt;
    op_valid = 1'b1; op_ir = IR_ADD; op_a = 16'h0F0F; op_b = 16'h0101;
    @(negedge clk);
    op_valid = 1'b0;
    lat = 1;
    while (!err_timeout && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("timeout_latency", 32'(lat), 32'(33));
    check("timeout_no_result", 32'(rv_cnt - rv0), 32'(0));
    check("timeout_res_data", 32'(res_data), 32'(m_res));
    check("timeout_flags", 32'(flags), 32'(m_flags));
    check("timeout_ready", 32'(op_ready), 32'(1));
    check("timeout_alu_ir", 32'(alu_ir), 32'(0));
    alu_stuck = 1'b0;
    run_op(IR_XOR, 16'hA5A5, 16'h0FF0);
    check("err_after_next", 32'(err_timeout), 32'(0));

    // reset pulsed while waiting for done-high
    rv0 = rv_cnt;
    op_valid = 1'b1; op_ir = IR_ADD; op_a = 16'h4000; op_b = 16'h4000;
    @(negedge clk);
    op_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midop_busy", 32'(op_ready), 32'(0));
    rst = 1'b1;
    #1;
    check("midop_rst_res_data", 32'(res_data), 32'(0));
    check("midop_rst_flags", 32'(flags), 32'(0));
    check("midop_rst_modes", 32'(modes), 32'(3'b001));
    check("midop_rst_alu", 32'({alu_start, alu_oe, alu_ir}), 32'(0));
    check("midop_rst_res_valid", 32'(res_valid), 32'(0));
    @(negedge clk);
    rst = 1'b0;
    m_res = 16'h0000; m_flags = 4'h0; m_modes = 3'b001;
    @(negedge clk);
    check("midop_ready_after", 32'(op_ready), 32'(1));
    repeat (12) @(negedge clk);
    check("midop_no_result", 32'(rv_cnt - rv0), 32'(0));

    // op_valid held high: one acceptance per completion, one start per op
    ha = 16'($urandom); hb = 16'($urandom);
    acc0 = acc_cnt; rv0 = rv_cnt; st0 = start_cnt;
    op_valid = 1'b1; op_ir = IR_XOR; op_a = ha; op_b = hb;
    repeat (30) @(negedge clk);
    op_valid = 1'b0;
    repeat (12) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      predict(IR_XOR, ha, hb, e_res, e_flags, e_modes);
      m_res = e_res; m_flags = e_flags; m_modes = e_modes;
    end
    check("hold_accepts", 32'(acc_cnt - acc0), 32'(3));
    check("hold_results", 32'(rv_cnt - rv0), 32'(3));
    check("hold_starts", 32'(start_cnt - st0), 32'(3));
    check("hold_res_data", 32'(res_data), 32'(m_res));
    check("hold_flags", 32'(flags), 32'(m_flags));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock; rst input 1, reset, asynchronous, active-high.
REQ-002 SHALL have CPU-side ports:
- op_valid in 1, request.
- op_ready out 1, high only in IDLE.
- op_ir in 10, instruction.
- op_a in 16, operand A.
- op_b in 16, operand B.
REQ-003 SHALL have result ports:
- res_valid out 1, one-cycle completion pulse.
- res_data out 16, last result.
- flags out 4, {Z,C,V,N}.
- modes out 3, {signed_en,carry_en,flags_en}.
- err_timeout out 1, sticky timeout.
REQ-004 SHALL have ALU-side outputs: alu_start 1, alu_ir 10, alu_a 16, alu_b 16, alu_oe 1, alu_carryin 1.
REQ-005 SHALL have ALU-side inputs: alu_done 1, alu_out 16, alu_carryout 1, alu_overout 1, alu_cmpo 1.
REQ-006 SHALL have parameter TIMEOUT, default 31, maximum cycles from ISSUE to done-high.

Function
REQ-007 SHALL use states IDLE, ISSUE, WAIT_LOW, WAIT_HIGH, CAPTURE, MODE, MODE_WAIT.
REQ-008 SHALL accept an op when op_valid && op_ready at a clock edge.
- On acceptance, latch op_ir, op_a and op_b.
- On acceptance, clear err_timeout.
REQ-009 SHALL route accepted ops by op_ir:
- 0x0BA..0x0BF go to MODE.
- All other values go to ISSUE.
REQ-010 SHALL, in IDLE, drive alu_start=0, alu_ir=0 and alu_oe=0.
REQ-011 SHALL, in ISSUE, drive alu_start=1 for exactly one cycle, then go to WAIT_LOW.
REQ-012 SHALL hold alu_ir, alu_a and alu_b at the latched values from ISSUE through CAPTURE inclusive.
REQ-013 SHALL, in WAIT_LOW, go to WAIT_HIGH once alu_done=0.
REQ-014 SHALL, in WAIT_HIGH, go to CAPTURE once alu_done=1.
REQ-015 SHALL, in any cycle of WAIT_LOW or WAIT_HIGH with alu_cmpo=1, latch alu_carryout and alu_overout into pending C/V and set a cmp_seen bit.
REQ-016 SHALL, in CAPTURE, drive alu_oe=1 and register res_data=alu_out; it then returns to IDLE with res_valid=1 for that one cycle.
REQ-017 SHALL update flags at CAPTURE only when cmp_seen=1 and flags_en=1:
- Z = (alu_out==0).
- N = alu_out[15].
- C and V from the pending values.
- If the op was 0x0B9, load flags=0 instead.
REQ-018 SHALL leave flags unchanged when the update condition of REQ-017 is false.
REQ-019 SHALL clear cmp_seen at ISSUE.
REQ-020 SHALL drive alu_carryin = C && carry_en continuously.
REQ-021 SHALL handle mode ops as follows:
- MODE: drive alu_ir=op_ir with alu_start=0 for exactly one cycle.
- MODE_WAIT: drive alu_ir=0 for one cycle.
- Then return to IDLE with res_valid=1 and res_data unchanged.
REQ-022 SHALL update the mirrored modes bit at MODE:
- 0xBA/0xBB clear/set flags_en.
- 0xBC/0xBD clear/set carry_en.
- 0xBE/0xBF clear/set signed_en.
REQ-023 SHALL run a 5-bit cycle counter, cleared at ISSUE and incremented in WAIT_LOW and WAIT_HIGH.
REQ-024 SHALL, on counter reaching TIMEOUT:
- set err_timeout=1;
- go to IDLE;
- leave res_valid, res_data and flags unchanged.
REQ-025 SHALL ignore op_valid while not in IDLE, with no queuing.
REQ-026 SHALL, with the team ALU attached, assert res_valid 10 cycles after the acceptance cycle for non-mode ops and 3 cycles after for mode ops.

Reset
REQ-027 SHALL, on rst=1, immediately force:
- state=IDLE;
- res_valid=0, res_data=0, flags=0, err_timeout=0;
- modes=3'b001 (flags_en=1, carry_en=0, signed_en=0);
- alu_start=0, alu_ir=0, alu_oe=0.
REQ-028 SHALL, when rst asserts mid-operation, abandon the op with no res_valid and no flag update.

Verification
REQ-029 SHALL pass the following directed scenarios:
- ADD ir, a=0x0001, b=0xFFFF with the team ALU -> res_valid at cycle +10, res_data=0x0000, Z=1, C=1, N=0.
- op 0x0BD, then an ADD with C=1 -> alu_carryin=1 throughout ISSUE..CAPTURE; modes[1]=1; mode-op res_valid at +3.
- op 0x0BA, then an op with cmpo -> flags unchanged; then op 0x0BB plus op 0x0B9 -> flags=0.
- ALU model that never drops alu_done -> err_timeout=1 after 31 WAIT cycles, no res_valid; the next accepted op clears err_timeout.
- rst pulsed in WAIT_HIGH -> outputs at reset values the same cycle, op_ready=1 after release, no res_valid.
- op_valid held high during busy -> exactly one acceptance per completion; alu_start is a single-cycle pulse per op.
